// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e : FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   clog2   : ceiling log2, used to size the digit counter
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rca_digit.sv
// Combinational DIGIT-bit ripple-carry slice built from full adders.
// Ports:
//   a, b  in  DIGIT  addend digits
//   ci    in  1      carry into bit 0
//   s     out DIGIT  digit sum
//   co    out 1      carry out of bit DIGIT-1
//   c_msb out 1      carry into bit DIGIT-1 (for signed overflow)
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign s[gi]     = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_digit_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock through one
// ripple-carry slice, so an operation takes NDIG = WIDTH/DIGIT RUN cycles.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, cin, sub sampled on accept)
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result, raw carry out of MSB, signed overflow
module addsub_digit_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CNTW = (NDIG > 1) ? clog2(NDIG) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    rca_digit #(.DIGIT(DIGIT)) u_slice (
        .a     (a_sr_q[DIGIT-1:0]),
        .b     (b_sr_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // a_sr doubles as the result shift register: as operand digits leave at
    // the bottom, sum digits enter at the top, so after NDIG shifts it holds
    // the complete result. b's vacated top bits are don't-care.
    if (DIGIT < WIDTH) begin : g_shift
        assign a_shift = {dig_s, a_sr_q[WIDTH-1:DIGIT]};
        assign b_shift = {{DIGIT{1'b0}}, b_sr_q[WIDTH-1:DIGIT]};
    end else begin : g_noshift
        assign a_shift = dig_s;
        assign b_shift = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction is a + ~b + 1; cin is ignored in that mode.
                    a_sr_d  = a;
                    b_sr_d  = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d  = a_shift;
                b_sr_d  = b_shift;
                carry_d = dig_co;
                cnt_d   = cnt_q + CNTW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Outputs only update here so they hold through IDLE/RUN.
                    cnt_d   = '0;
                    sum_d   = a_shift;
                    cout_d  = dig_co;
                    ovf_d   = dig_cmsb ^ dig_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
